sram_bank_param: RTL
====================

// Module: sram_bank_param
// PURPOSE
//  Parametrised single-port, byte-writable SRAM bank; next generation of the 128x32 data SRAM.
//  Adds configurable width/depth, a valid/ready request port, registered read data with rsp_valid,
//  and a post-reset hardware clear sequencer. Sits between the LSU/fetch arbiter and storage.
// PARAMETERS
//  DATA_W    32             word width in bits; must be a multiple of 8
//  DEPTH     128            number of words; need not be a power of two
//  INIT_VAL  {DATA_W{1'b0}} value written to every word by the clear sequencer
//  ADDR_W    $clog2(DEPTH)  derived (localparam); address width
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  reset       in   1         synchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid   in   1         request present
//  req_ready   out  1         bank can accept a request this cycle
//  req_we      in   1         1 = write, 0 = read
//  req_addr    in   ADDR_W    word address
//  req_be      in   DATA_W/8  byte enables (writes only; ignored for reads)
//  req_wdata   in   DATA_W    write data
//  rsp_valid   out  1         read data valid (1-cycle pulse per accepted read)
//  rsp_rdata   out  DATA_W    read data, registered
//  init_busy   out  1         clear sequencer running
//  parity_err  out  1         parity mismatch on the current response (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state<=CLEAR, clr_addr<=0, req_ready=0, rsp_valid<=0,
//   rsp_rdata<=0, parity_err<=0, init_busy=1. Array contents are not reset directly.
//  FSM states: CLEAR, RUN.
//   CLEAR: each cycle, write INIT_VAL to mem[clr_addr] and increment clr_addr.
//     On the cycle that writes DEPTH-1, go to RUN. Lasts exactly DEPTH cycles after reset release.
//   RUN: req_ready=1 combinationally; init_busy=0. Stays in RUN until reset.
//  Handshake: request accepted when req_valid && req_ready at a clk edge. One request per cycle.
//   The bank never stalls in RUN; req_valid during CLEAR is ignored (no response, no write).
//  Write (accept cycle N): for each byte b with req_be[b]==1, mem[addr][8b+7:8b] <= wdata byte;
//   bytes with be==0 are unchanged. req_be==0 is accepted as a no-op.
//   No response: rsp_valid stays 0 in N+1.
//  Read (accept cycle N): rsp_valid=1 and rsp_rdata=mem[addr] in cycle N+1 (latency 1).
//   A read in cycle N+1 sees a write accepted in cycle N to the same address (write-then-read ordering).
//  rsp_rdata holds its last value when rsp_valid==0; rsp_valid is high for exactly one cycle per read.
//  Out of range (req_addr >= DEPTH): write dropped; read still responds at N+1 with rsp_rdata=0 and
//   parity_err=0.
//  Back-to-back reads: one response per cycle, in request order, no bubbles.
//  Reset mid-operation: a pending read response is squashed (rsp_valid=0 in the next cycle);
//   CLEAR restarts from address 0; any partial earlier clear is redone.
// CONFIGURATION
//  Macro SRAM_BANK_PARITY_EN:
//   Defined: one even-parity bit per byte, stored alongside the data. A write updates parity only for
//    enabled bytes; CLEAR writes parity of INIT_VAL. On read response, parity_err=1 at N+1 if any byte's
//    stored parity != recomputed parity; parity_err is valid only with rsp_valid, else 0.
//    Data is still returned unchanged. A debug-only task force_parity_flip(addr,byte) (sim only)
//    inverts one stored parity bit.
//   Undefined: no parity storage; parity_err tied to 0. Port list is identical in both builds.
// TESTING
//  1 Reset release, DEPTH=128: init_busy=1 and req_ready=0 for exactly 128 cycles, then req_ready=1;
//    reading addr 0/64/127 gives 0x00000000.
//  2 Write addr 5, be=4'b1111, data 0xDEADBEEF; then write addr 5, be=4'b0010, data 0x0000AA00;
//    read 5 -> rsp_valid one cycle later, rdata 0xDEADAAEF.
//  3 Write addr 9 = 0x12345678, read 9 the very next cycle -> 0x12345678; reads of 9, 10, 11 back to back
//    -> three consecutive rsp_valid pulses in order.
//  4 DEPTH=100: write addr 100 = 0xFFFFFFFF, then read 100 -> rdata 0; read 99 -> 0 (INIT_VAL unchanged).
//  5 Read addr 3 accepted, reset=0 on next edge -> rsp_valid stays 0; CLEAR reruns for 128 cycles;
//    earlier data at addr 3 reads back 0.
//  6 SRAM_BANK_PARITY_EN: write addr 7 = 0xA5A5A5A5, force_parity_flip(7,2), read 7 -> rdata 0xA5A5A5A5,
//    parity_err=1; read addr 5 -> parity_err=0. Macro off: parity_err always 0.

Source files
------------

// File: rtl/sram_bank_param.sv
// Parametrised single-port byte-writable SRAM bank with valid/ready request port and post-reset clear.
// Optional per-byte even parity storage and checking is enabled with `define SRAM_BANK_PARITY_EN.
module sram_bank_param #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 128,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0,
    localparam int unsigned         ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned         NB       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [NB-1:0]     req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_busy,
    output logic              parity_err
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_we, accept, in_range, wr_en, rd_en, rd_perr;
    logic              rsp_valid_q, parity_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = {1'b0, req_addr} < DepthW;
    // Requests seen while reset is low are never accepted, even if the FSM is still in RUN.
    assign accept   = reset && req_valid && req_ready;
    assign wr_en    = accept && req_we && in_range;
    assign rd_en    = accept && !req_we;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        req_ready  = 1'b0;
        init_busy  = 1'b1;
        unique case (state_q)
            StClear: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LastAddr) begin
                    state_d    = StRun;
                    clr_addr_d = '0;
                end
            end
            StRun: begin
                req_ready = 1'b1;
                init_busy = 1'b0;
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StClear;
            clr_addr_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            rsp_valid_q  <= rd_en;
            parity_err_q <= 1'b0;
            if (rd_en) begin
                rsp_rdata_q  <= in_range ? mem[req_addr] : '0;
                parity_err_q <= rd_perr;
            end
        end
    end

    // Clear and request writes are exclusive: requests are only accepted in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clr_we) begin
                mem[clr_addr_q] <= INIT_VAL;
            end else if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef SRAM_BANK_PARITY_EN
    function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction

    logic [NB-1:0]     par_mem [DEPTH];
    logic              flip_tgl  = 1'b0;
    logic              flip_tgl_q;
    logic [ADDR_W-1:0] flip_addr = '0;
    logic [NB-1:0]     flip_mask = '0;

    // Debug flips are posted by toggling flip_tgl and applied on the next clock edge.
    always_ff @(posedge clk) begin
        flip_tgl_q <= flip_tgl;
        if (flip_tgl != flip_tgl_q) begin
            par_mem[flip_addr] <= par_mem[flip_addr] ^ flip_mask;
        end else if (reset) begin
            if (clr_we) begin
                par_mem[clr_addr_q] <= byte_parity(INIT_VAL);
            end else if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_be[b]) par_mem[req_addr][b] <= ^req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_perr = in_range && (byte_parity(mem[req_addr]) != par_mem[req_addr]);

    task automatic force_parity_flip(input int unsigned addr, input int unsigned bidx);
        flip_addr = ADDR_W'(addr);
        flip_mask = NB'(1) << bidx;
        flip_tgl  = ~flip_tgl;
    endtask
`else
    assign rd_perr = 1'b0;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign parity_err = parity_err_q;

endmodule
